// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared FSM state type and width helper for the multiplier arbiter
package multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Product of two BITS-wide operands.
    function automatic int product_width(input int bits);
        return 2 * bits;
    endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// rtl/multiplier_arbiter_if.sv - client request/response bus plus multiplier control bus
//
// Signals (arbiter view, modport slave):
//   req_valid/req_ready          per-client request handshake, ready is one-hot or zero
//   req_multiplier/multiplicand  packed operands, client k at [k*BITS +: BITS]
//   rsp_valid/rsp_ready          per-client response handshake, valid is one-hot or zero
//   rsp_product/rsp_error        shared response payload
//   mul_start/mul_multiplier/mul_multiplicand  drive the shared multiplier
//   mul_finished/mul_product     multiplier completion and result
//   busy                         arbiter not idle
// Modport master is the environment side (clients plus the multiplier).
interface multiplier_arbiter_if
    import multiplier_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int REQUESTERS = 4
);
    localparam int PW = product_width(BITS);

    logic [REQUESTERS-1:0]      req_valid;
    logic [REQUESTERS-1:0]      req_ready;
    logic [REQUESTERS*BITS-1:0] req_multiplier;
    logic [REQUESTERS*BITS-1:0] req_multiplicand;
    logic [REQUESTERS-1:0]      rsp_valid;
    logic [REQUESTERS-1:0]      rsp_ready;
    logic [PW-1:0]              rsp_product;
    logic                       rsp_error;
    logic                       mul_start;
    logic [BITS-1:0]            mul_multiplier;
    logic [BITS-1:0]            mul_multiplicand;
    logic                       mul_finished;
    logic [PW-1:0]              mul_product;
    logic                       busy;

    modport slave (
        input  req_valid, req_multiplier, req_multiplicand, rsp_ready,
               mul_finished, mul_product,
        output req_ready, rsp_valid, rsp_product, rsp_error,
               mul_start, mul_multiplier, mul_multiplicand, busy
    );

    modport master (
        output req_valid, req_multiplier, req_multiplicand, rsp_ready,
               mul_finished, mul_product,
        input  req_ready, rsp_valid, rsp_product, rsp_error,
               mul_start, mul_multiplier, mul_multiplicand, busy
    );

endinterface

// File: rtl/multiplier_arbiter_rr_arbiter.sv
// rtl/multiplier_arbiter_rr_arbiter.sv - combinational round-robin grant selection
//
// Ports:
//   req         request vector
//   last_grant  index of the previously accepted client
//   grant       one-hot winner (zero when no request)
//   grant_idx   binary index of the winner
//   any         at least one request present
module rr_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      last_grant,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  any
);

    logic [IDX_W-1:0] idx;

    // Walk from last_grant+1 around to last_grant itself; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % REQUESTERS);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// rtl/multiplier_arbiter.sv - round-robin sharing of one sequential multiplier among clients
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN (WAIT watchdog, error response).
//
// Ports:
//   i_clock    rising-edge clock
//   i_reset_n  synchronous active-low reset
//   bus        multiplier_arbiter_if.slave: client request/response buses and
//              multiplier start/operand/finished/product signals, plus busy
module multiplier_arbiter
    import multiplier_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    multiplier_arbiter_if.slave   bus
);

    localparam int PW = product_width(BITS);
    localparam int IW = $clog2(REQUESTERS);

    state_t                state_q;
    state_t                state_d;
    // Doubles as the round-robin pointer: it only changes on an accepted request.
    logic [IW-1:0]         grant_idx_q;
    logic [BITS-1:0]       mul_a_q;
    logic [BITS-1:0]       mul_b_q;
    logic [PW-1:0]         product_q;

    logic [REQUESTERS-1:0] arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;
    logic                  timed_out;
    logic                  rsp_hs;

    rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IW)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (grant_idx_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // Only the granted client's ready bit can complete the response.
    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready[grant_idx_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (arb_any) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (bus.mul_finished || timed_out) state_d = ST_RESP;
            ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (state_q == ST_IDLE) begin
            bus.req_ready = arb_grant;
        end
        if (state_q == ST_RESP) begin
            bus.rsp_valid = REQUESTERS'(1) << grant_idx_q;
        end
    end

    assign bus.mul_start        = (state_q == ST_START);
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.mul_multiplier   = mul_a_q;
    assign bus.mul_multiplicand = mul_b_q;
    assign bus.rsp_product      = product_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= IW'(REQUESTERS - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            product_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && arb_any) begin
                grant_idx_q <= arb_idx;
                mul_a_q     <= bus.req_multiplier[int'(arb_idx) * BITS +: BITS];
                mul_b_q     <= bus.req_multiplicand[int'(arb_idx) * BITS +: BITS];
            end
            // finished strobes outside WAIT never touch the product.
            if (state_q == ST_WAIT) begin
                if (bus.mul_finished) begin
                    product_q <= bus.mul_product;
                end else if (timed_out) begin
                    product_q <= '0;
                end
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;
    logic          error_q;

    // Held at zero outside WAIT, so every WAIT visit starts counting from 0.
    assign timed_out = (state_q == ST_WAIT) && !bus.mul_finished &&
                       (wait_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            wait_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
            if (timed_out) begin
                error_q <= 1'b1;
            end else if (rsp_hs) begin
                error_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_error = error_q;
`else
    localparam int timeout_unused = TIMEOUT;

    assign timed_out     = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb/tb_multiplier_arbiter.sv - self-checking bench for multiplier_arbiter
module tb_multiplier_arbiter;

    localparam int BITS = 8;
    localparam int R    = 4;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    multiplier_arbiter_if #(.BITS(BITS), .REQUESTERS(R)) bus ();

    multiplier_arbiter #(
        .BITS       (BITS),
        .REQUESTERS (R),
        .TIMEOUT    (TO)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rstn),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit   [R-1:0] pending;
    logic [7:0]   opa [R];
    logic [7:0]   opb [R];
    int           last;
    int           stub_lat = -1;
    int           stub_cd  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Multiplier model: finishes lat cycles into WAIT, and throws spurious
    // finished strobes with junk products while a response is pending.
    initial begin
        bus.mul_finished = 1'b0;
        bus.mul_product  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mul_finished = 1'b0;
            if (!rstn) begin
                stub_cd = 0;
            end else begin
                if (stub_cd > 0) begin
                    stub_cd--;
                    if (stub_cd == 0) begin
                        bus.mul_finished = 1'b1;
                        bus.mul_product  = 16'(bus.mul_multiplier) * 16'(bus.mul_multiplicand);
                    end
                end else if (bus.rsp_valid != '0 && $urandom_range(0, 1) == 1) begin
                    bus.mul_finished = 1'b1;
                    bus.mul_product  = 16'hBEEF;
                end
                if (bus.mul_start === 1'b1 && stub_lat >= 0) stub_cd = stub_lat + 1;
            end
        end
    end

    function automatic int pick();
        for (int i = 1; i <= R; i++) begin
            int k;
            k = (last + i) % R;
            if (pending[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        bus.req_valid = pending;
        for (int k = 0; k < R; k++) begin
            bus.req_multiplier[k*BITS +: BITS]   = opa[k];
            bus.req_multiplicand[k*BITS +: BITS] = opb[k];
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_product"}, bus.rsp_product, 0);
        chk({tag, "_rsp_error"}, bus.rsp_error, 0);
        chk({tag, "_mul_start"}, bus.mul_start, 0);
        chk({tag, "_mul_multiplier"}, bus.mul_multiplier, 0);
        chk({tag, "_mul_multiplicand"}, bus.mul_multiplicand, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    // One full transaction for client w; lat < 0 means the multiplier never finishes.
    task automatic serve(input int w, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input int stall);
        logic [R-1:0] oh;
        logic [R-1:0] noise;
        logic [15:0]  exp_p;
        int           n;
        bit           seen;
        oh    = R'(1) << w;
        exp_p = (lat < 0) ? 16'h0 : 16'(a) * 16'(b);
        stub_lat = lat;
        #1;
        chk("req_ready_grant", bus.req_ready, oh);
        chk("busy_in_idle", bus.busy, 0);
        next_cycle();
        bus.req_valid[w] = 1'b0;
        #1;
        chk("mul_start", bus.mul_start, 1);
        chk("mul_multiplier", bus.mul_multiplier, a);
        chk("mul_multiplicand", bus.mul_multiplicand, b);
        chk("busy_after_accept", bus.busy, 1);
        noise = R'($urandom) & ~oh;
        bus.rsp_ready = noise | ((stall == 0) ? oh : '0);
        n    = 1;
        seen = 0;
        while (!seen && n < 200) begin
            next_cycle();
            n++;
            #1;
            if (bus.rsp_valid != '0) seen = 1;
            else chk("no_accept_while_busy", bus.req_ready, 0);
        end
        chk("rsp_latency", n, (lat < 0) ? 2 + TO : 3 + lat);
        chk("rsp_valid", bus.rsp_valid, oh);
        chk("rsp_product", bus.rsp_product, exp_p);
        chk("rsp_error", bus.rsp_error, (lat < 0) ? 1 : 0);
        for (int s = 0; s < stall; s++) begin
            next_cycle();
            #1;
            chk("rsp_valid_hold", bus.rsp_valid, oh);
            chk("rsp_product_hold", bus.rsp_product, exp_p);
            chk("no_accept_in_resp", bus.req_ready, 0);
        end
        bus.rsp_ready = noise | oh;
        next_cycle();
        bus.rsp_ready = '0;
        #1;
        chk("busy_after_hs", bus.busy, 0);
        chk("rsp_valid_after_hs", bus.rsp_valid, 0);
        chk("rsp_error_after_hs", bus.rsp_error, 0);
        stub_lat = -1;
    endtask

    task automatic issue(input int lat, input int stall, input bit refill);
        int w;
        w = pick();
        drive_reqs();
        serve(w, opa[w], opb[w], lat, stall);
        last = w;
        if (!refill) pending[w] = 1'b0;
        drive_reqs();
    endtask

    initial begin
        int w;
        int hold;
        rstn          = 1'b0;
        pending       = '0;
        bus.rsp_ready = '0;
        for (int k = 0; k < R; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        drive_reqs();
        last = R - 1;

        // Reset for two cycles, then release.
        next_cycle();
        next_cycle();
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        next_cycle();
        #1;
        check_all_zero("post_reset");

        // Client 0: 7 x 9, finished 8 cycles into WAIT -> response at cycle 11.
        pending[0] = 1'b1;
        opa[0] = 8'd7;
        opb[0] = 8'd9;
        issue(8, 1, 0);

        // Clients 1 and 3 continuously valid: grants must alternate 1,3,1,3.
        pending = '0;
        pending[1] = 1'b1; opa[1] = 8'd3;   opb[1] = 8'd5;
        pending[3] = 1'b1; opa[3] = 8'd255; opb[3] = 8'd255;
        for (int i = 0; i < 4; i++) begin
            chk("alternating_grant", pick(), (i % 2 == 0) ? 1 : 3);
            issue($urandom_range(0, 3), 0, 1);
        end
        pending = '0;
        drive_reqs();

        // Long response stall on client 2 while client 3 waits.
        pending[2] = 1'b1; opa[2] = 8'($urandom); opb[2] = 8'($urandom);
        pending[3] = 1'b1; opa[3] = 8'($urandom); opb[3] = 8'($urandom);
        issue(2, 20, 0);
        issue(1, 0, 0);

`ifdef MULT_ARB_TIMEOUT_EN
        // Multiplier never finishes: watchdog produces an error response.
        pending[1] = 1'b1; opa[1] = 8'($urandom); opb[1] = 8'($urandom);
        issue(-1, 2, 0);
        hold = 5;
`else
        hold = 40;
`endif

        // Hang in WAIT, then reset mid-operation.
        pending[2] = 1'b1; opa[2] = 8'($urandom); opb[2] = 8'($urandom);
        w = pick();
        drive_reqs();
        stub_lat = -1;
        #1;
        chk("hang_grant", bus.req_ready, R'(1) << w);
        next_cycle();
        pending = '0;
        drive_reqs();
        for (int i = 0; i < hold; i++) next_cycle();
        #1;
        chk("hang_busy", bus.busy, 1);
        chk("hang_no_rsp", bus.rsp_valid, 0);
        rstn = 1'b0;
        next_cycle();
        #1;
        check_all_zero("mid_reset");
        rstn = 1'b1;
        last = R - 1;

        // All clients valid after reset: client 0 must win first.
        for (int k = 0; k < R; k++) begin
            pending[k] = 1'b1;
            opa[k] = 8'($urandom);
            opb[k] = 8'($urandom);
        end
        chk("first_after_reset", pick(), 0);
        issue($urandom_range(0, 4), 0, 0);

        // Randomized traffic against the round-robin / product model.
        for (int t = 0; t < 30; t++) begin
            for (int k = 0; k < R; k++) begin
                if (!pending[k] && $urandom_range(0, 1) == 1) begin
                    pending[k] = 1'b1;
                    opa[k] = 8'($urandom);
                    opb[k] = 8'($urandom);
                end
            end
            if (pending == '0) begin
                w = $urandom_range(0, R - 1);
                pending[w] = 1'b1;
                opa[w] = 8'($urandom);
                opb[w] = 8'($urandom);
            end
            issue($urandom_range(0, 5), $urandom_range(0, 3), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
